// File: rtl/islemci_bekleme.sv
// Multicycle RV32I/RV32E core with a shared, wait-state tolerant memory port.
// One instruction in flight: GETIR -> COZ -> YURUT [-> BELLEK] -> GETIR, halt in DUR.
module islemci_bekleme #(
    parameter logic [31:0] BELLEK_ADRES  = 32'h8000_0000,
    parameter int unsigned YAZMAC_SAYISI = 32,
    parameter int unsigned ADRES_BIT     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 bellek_istek,
    input  logic                 bellek_hazir,
    output logic [ADRES_BIT-1:0] bellek_adres,
    output logic                 bellek_yaz,
    output logic [31:0]          bellek_yaz_veri,
    input  logic [31:0]          bellek_oku_veri,
    output logic [ADRES_BIT-1:0] ps,
    output logic                 emekli,
    output logic                 hata
);
    localparam int unsigned IB = $clog2(YAZMAC_SAYISI);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_DAL   = 7'b1100011;
    localparam logic [6:0] OP_YUK   = 7'b0000011;
    localparam logic [6:0] OP_SAK   = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    typedef enum logic [2:0] {GETIR, COZ, YURUT, BELLEK, DUR} durum_t;
    durum_t durum, sonraki;

    logic [31:0] pc, komut, rs1_d, rs2_d, ea;
    logic [31:0] yazmac [YAZMAC_SAYISI];

    logic [6:0]  opk, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opk = komut[6:0];
    assign rd  = komut[11:7];
    assign f3  = komut[14:12];
    assign rs1 = komut[19:15];
    assign rs2 = komut[24:20];
    assign f7  = komut[31:25];

    assign imm_i = {{20{komut[31]}}, komut[31:20]};
    assign imm_s = {{20{komut[31]}}, komut[31:25], komut[11:7]};
    assign imm_b = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
    assign imm_u = {komut[31:12], 12'b0};
    assign imm_j = {{11{komut[31]}}, komut[31], komut[19:12], komut[20], komut[30:21], 1'b0};

    logic [31:0] rs1_oku, rs2_oku;
    assign rs1_oku = (32'(rs1) < YAZMAC_SAYISI) ? yazmac[rs1[IB-1:0]] : '0;
    assign rs2_oku = (32'(rs2) < YAZMAC_SAYISI) ? yazmac[rs2[IB-1:0]] : '0;

    // Decode legality: only the register fields an instruction actually uses are range-checked
    logic gecerli, rs1_k, rs2_k, rd_k, yazmac_hata;
    always_comb begin
        gecerli = 1'b0;
        rs1_k   = 1'b0;
        rs2_k   = 1'b0;
        rd_k    = 1'b0;
        case (opk)
            OP_LUI, OP_AUIPC, OP_JAL: begin gecerli = 1'b1; rd_k = 1'b1; end
            OP_JALR: begin gecerli = (f3 == 3'b000); rs1_k = 1'b1; rd_k = 1'b1; end
            OP_DAL:  begin gecerli = (f3 != 3'b010) && (f3 != 3'b011); rs1_k = 1'b1; rs2_k = 1'b1; end
            OP_YUK:  begin gecerli = (f3 == 3'b010); rs1_k = 1'b1; rd_k = 1'b1; end
            OP_SAK:  begin gecerli = (f3 == 3'b010); rs1_k = 1'b1; rs2_k = 1'b1; end
            OP_ALUI: begin
                gecerli = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                          (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
                rs1_k = 1'b1;
                rd_k  = 1'b1;
            end
            OP_ALU: begin
                gecerli = (f7 == 7'b0000000) ||
                          (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                rs1_k = 1'b1;
                rs2_k = 1'b1;
                rd_k  = 1'b1;
            end
            default: ;
        endcase
        yazmac_hata = (rs1_k && 32'(rs1) >= YAZMAC_SAYISI) ||
                      (rs2_k && 32'(rs2) >= YAZMAC_SAYISI) ||
                      (rd_k  && 32'(rd)  >= YAZMAC_SAYISI);
    end

    logic [31:0] alu_b, alu, sra_sonuc, yeni_pc, rd_deger, ea_h;
    logic        alindi, rd_yaz, bellek_islem, hedef_hata;
    always_comb begin
        alu_b     = (opk == OP_ALU) ? rs2_d : imm_i;
        sra_sonuc = $signed(rs1_d) >>> alu_b[4:0];
        case (f3)
            3'b000:  alu = (opk == OP_ALU && f7[5]) ? rs1_d - alu_b : rs1_d + alu_b;
            3'b001:  alu = rs1_d << alu_b[4:0];
            3'b010:  alu = {31'b0, $signed(rs1_d) < $signed(alu_b)};
            3'b011:  alu = {31'b0, rs1_d < alu_b};
            3'b100:  alu = rs1_d ^ alu_b;
            3'b101:  alu = f7[5] ? sra_sonuc : rs1_d >> alu_b[4:0];
            3'b110:  alu = rs1_d | alu_b;
            default: alu = rs1_d & alu_b;
        endcase
        case (f3)
            3'b000:  alindi = (rs1_d == rs2_d);
            3'b001:  alindi = (rs1_d != rs2_d);
            3'b100:  alindi = ($signed(rs1_d) <  $signed(rs2_d));
            3'b101:  alindi = ($signed(rs1_d) >= $signed(rs2_d));
            3'b110:  alindi = (rs1_d <  rs2_d);
            3'b111:  alindi = (rs1_d >= rs2_d);
            default: alindi = 1'b0;
        endcase
        yeni_pc      = pc + 32'd4;
        rd_deger     = alu;
        rd_yaz       = 1'b0;
        bellek_islem = 1'b0;
        case (opk)
            OP_LUI:   begin rd_deger = imm_u; rd_yaz = 1'b1; end
            OP_AUIPC: begin rd_deger = pc + imm_u; rd_yaz = 1'b1; end
            OP_JAL:   begin rd_deger = pc + 32'd4; yeni_pc = pc + imm_j; rd_yaz = 1'b1; end
            OP_JALR:  begin rd_deger = pc + 32'd4; yeni_pc = (rs1_d + imm_i) & ~32'd1; rd_yaz = 1'b1; end
            OP_DAL:   if (alindi) yeni_pc = pc + imm_b;
            OP_YUK, OP_SAK: bellek_islem = 1'b1;
            OP_ALU, OP_ALUI: rd_yaz = 1'b1;
            default: ;
        endcase
        ea_h       = rs1_d + ((opk == OP_SAK) ? imm_s : imm_i);
        hedef_hata = bellek_islem ? (ea_h[1:0] != 2'b00) : (yeni_pc[1:0] != 2'b00);
    end

    logic        rf_yaz;
    logic [31:0] rf_deger;
    always_comb begin
        sonraki         = durum;
        bellek_istek    = 1'b0;
        bellek_yaz      = 1'b0;
        bellek_yaz_veri = '0;
        bellek_adres    = BELLEK_ADRES[ADRES_BIT-1:0];
        emekli          = 1'b0;
        rf_yaz          = 1'b0;
        rf_deger        = rd_deger;
        case (durum)
            GETIR: begin
                bellek_istek = 1'b1;
                bellek_adres = pc[ADRES_BIT-1:0];
                if (bellek_hazir) sonraki = COZ;
            end
            COZ: sonraki = (!gecerli || yazmac_hata) ? DUR : YURUT;
            YURUT: begin
                if (hedef_hata)        sonraki = DUR;
                else if (bellek_islem) sonraki = BELLEK;
                else begin
                    emekli  = 1'b1;
                    rf_yaz  = rd_yaz;
                    sonraki = GETIR;
                end
            end
            BELLEK: begin
                bellek_istek    = 1'b1;
                bellek_adres    = ea[ADRES_BIT-1:0];
                bellek_yaz      = (opk == OP_SAK);
                bellek_yaz_veri = (opk == OP_SAK) ? rs2_d : '0;
                if (bellek_hazir) begin
                    emekli   = 1'b1;
                    rf_yaz   = (opk == OP_YUK);
                    rf_deger = bellek_oku_veri;
                    sonraki  = GETIR;
                end
            end
            default: ;
        endcase
        // Reset overrides the bus combinationally so an open transfer is dropped in the same cycle
        if (!rst) begin
            bellek_istek    = 1'b0;
            bellek_yaz      = 1'b0;
            bellek_yaz_veri = '0;
            bellek_adres    = BELLEK_ADRES[ADRES_BIT-1:0];
            emekli          = 1'b0;
            rf_yaz          = 1'b0;
        end
    end

    assign ps   = pc[ADRES_BIT-1:0];
    assign hata = (durum == DUR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            durum <= GETIR;
            pc    <= BELLEK_ADRES;
            komut <= '0;
            rs1_d <= '0;
            rs2_d <= '0;
            ea    <= '0;
            for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) yazmac[IB'(i)] <= '0;
        end else begin
            durum <= sonraki;
            if (durum == GETIR && bellek_hazir) komut <= bellek_oku_veri;
            if (durum == COZ) begin
                rs1_d <= rs1_oku;
                rs2_d <= rs2_oku;
            end
            if (durum == YURUT) begin
                ea <= ea_h;
                if (!hedef_hata && !bellek_islem) pc <= yeni_pc;
            end
            if (durum == BELLEK && bellek_hazir) pc <= pc + 32'd4;
            if (rf_yaz && rd != 5'd0) yazmac[rd[IB-1:0]] <= rf_deger;
        end
    end
endmodule

// File: tb/tb_islemci_bekleme.sv
// Bench for islemci_bekleme: memory model with wait injection, retire-PC and store scoreboards.
module tb_islemci_bekleme;
    logic        clk, rst, bellek_istek, bellek_hazir, bellek_yaz, emekli, hata;
    logic [31:0] bellek_adres, bellek_yaz_veri, bellek_oku_veri, ps;

    localparam logic [31:0] A = 32'h8000_0000;
    localparam logic [31:0] D = 32'h8000_1000;
    localparam logic [6:0] OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17, LOAD = 7'h03, JALR = 7'h67;

    islemci_bekleme #(.BELLEK_ADRES(32'h8000_0000), .YAZMAC_SAYISI(32), .ADRES_BIT(32)) dut (
        .clk(clk), .rst(rst), .bellek_istek(bellek_istek), .bellek_hazir(bellek_hazir),
        .bellek_adres(bellek_adres), .bellek_yaz(bellek_yaz), .bellek_yaz_veri(bellek_yaz_veri),
        .bellek_oku_veri(bellek_oku_veri), .ps(ps), .emekli(emekli), .hata(hata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {logic [31:0] a; logic [31:0] v;} yazma_t;
    yazma_t      yq[$];
    logic [31:0] psq[$];
    logic [31:0] prog [1024];
    logic [31:0] dmem [1024];
    int unsigned yer, toplam, hata_say, cyc, yasak, ilk_say, emk_n, faz;
    int unsigned bekle_yaz = 3;
    logic        ilk_bitti;
    logic [31:0] tut_adres;

    assign bellek_oku_veri = bellek_adres[12] ? dmem[bellek_adres[11:2]] : prog[bellek_adres[11:2]];

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hata_say++;
            $display("FAIL %s: gozlenen=%h beklenen=%h t=%0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    function automatic logic [31:0] e_i(input int imm, input int r1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(r1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_r(input int f7, input int r2, input int r1, input int f3, input int rd);
        return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] e_s(input int imm, input int r2, input int r1);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(r2), 5'(r1), 3'b010, t[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input int r2, input int r1, input int f3);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(r2), 5'(r1), 3'(f3), t[4:1], t[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_u(input int imm, input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm;
        return {t[19:0], 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input int rd);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'h6f};
    endfunction

    task automatic k(input logic [31:0] x);
        prog[yer >> 2] = x;
        yer += 4;
    endtask
    task automatic bw(input int unsigned off, input logic [31:0] v);
        yazma_t y;
        y.a = D + off;
        y.v = v;
        yq.push_back(y);
    endtask
    task automatic temizle();
        for (int i = 0; i < 1024; i++) prog[i] = '0;
        yer = 0;
    endtask

    // Memory/bus monitor: decides hazir for the cycle, then samples settled outputs
    initial begin
        logic [31:0] p;
        bellek_hazir = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) cyc = 0; else cyc++;
            if (bellek_istek && bellek_adres == tut_adres) bellek_hazir = 1'b0;
            else if (bellek_istek && bellek_yaz && bekle_yaz > 0) begin
                bellek_hazir = 1'b0;
                bekle_yaz--;
            end else bellek_hazir = 1'b1;
            #1;
            if (cyc == 1) begin
                kontrol("ilk_istek", {31'b0, bellek_istek}, 32'd1);
                kontrol("ilk_adres", bellek_adres, A);
            end
            if (bellek_istek && bellek_adres[1:0] != 2'b00) yasak++;
            if (emekli) begin
                if (psq.size() == 0) kontrol("emk_fazla", ps, 32'hFFFF_FFFF);
                else begin
                    p = psq.pop_front();
                    kontrol("emk_ps", ps, p);
                end
                if (faz == 1) begin
                    emk_n++;
                    if (emk_n <= 4) kontrol("emk_cyc", cyc, 3 * emk_n);
                    if (emk_n == 6) kontrol("sw_cyc", cyc, 22);
                end
            end
            if (bellek_istek && bellek_yaz) begin
                if (faz == 1 && !ilk_bitti) ilk_say++;
                if (yq.size() == 0) kontrol("yaz_fazla", bellek_adres, 32'hFFFF_FFFF);
                else begin
                    kontrol("yaz_adres", bellek_adres, yq[0].a);
                    kontrol("yaz_veri", bellek_yaz_veri, yq[0].v);
                    if (bellek_hazir) begin
                        dmem[bellek_adres[11:2]] = bellek_yaz_veri;
                        void'(yq.pop_front());
                        ilk_bitti = 1'b1;
                    end
                end
            end
        end
    end

    task automatic sifirla();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 kontrol("rst_istek", {31'b0, bellek_istek}, 32'd0);
        kontrol("rst_emekli", {31'b0, emekli}, 32'd0);
    endtask

    task automatic dur_bekle(input string etiket);
        for (int i = 0; i < 3000 && !hata; i++) @(posedge clk);
        #2 kontrol(etiket, {31'b0, hata}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; faz = 1; tut_adres = 32'hFFFF_FFF0; ilk_bitti = 1'b0;
        toplam = 0; hata_say = 0; yasak = 0; ilk_say = 0; emk_n = 0;
        temizle();
        k(e_i(-5, 0, 0, 1, OPI));      k(e_i(32'h401, 1, 5, 2, OPI)); k(e_i(28, 1, 5, 3, OPI));
        k(e_r(0, 1, 0, 3, 4));         k(e_u(32'h80001, 5, LUI));
        k(e_s(0, 1, 5)); k(e_s(4, 2, 5)); k(e_s(8, 3, 5)); k(e_s(12, 4, 5));
        k(e_i(0, 5, 2, 6, LOAD));      k(e_s(16, 6, 5));
        k(e_b(8, 4, 1, 6));            k(e_j(16, 0));  k(e_i(1, 7, 0, 7, OPI));
        k(e_j(16, 0));                 k(e_i(2, 7, 0, 7, OPI));
        k(e_b(-8, 4, 1, 4));           k(e_i(3, 7, 0, 7, OPI));
        k(e_s(20, 0, 5)); k(e_s(24, 7, 5));
        k(e_r(0, 4, 1, 0, 8));  k(e_r(32, 1, 4, 0, 9));  k(e_r(0, 3, 4, 1, 10));
        k(e_r(0, 4, 1, 2, 11)); k(e_r(0, 3, 1, 4, 12));  k(e_r(32, 4, 1, 5, 13));
        k(e_r(0, 4, 1, 5, 14)); k(e_r(0, 4, 3, 6, 15));  k(e_r(0, 3, 1, 7, 16));
        for (int i = 0; i < 9; i++) k(e_s(28 + 4 * i, 8 + i, 5));
        k(e_i(-4, 1, 2, 17, OPI));  k(e_i(-1, 4, 3, 18, OPI));     k(e_i(-1, 3, 4, 19, OPI));
        k(e_i(32'h7F0, 4, 6, 20, OPI)); k(e_i(32'h0F0, 1, 7, 21, OPI)); k(e_i(31, 3, 1, 22, OPI));
        k(e_u(1, 23, AUIPC));
        for (int i = 0; i < 7; i++) k(e_s(64 + 4 * i, 17 + i, 5));
        k(e_b(8, 4, 4, 0)); k(e_i(1, 7, 0, 7, OPI)); k(e_b(8, 4, 4, 1)); k(e_b(8, 4, 1, 5));
        k(e_b(8, 4, 1, 7)); k(e_i(1, 7, 0, 7, OPI)); k(e_u(0, 25, AUIPC));
        k(e_i(13, 25, 0, 24, JALR)); k(e_i(1, 7, 0, 7, OPI));
        k(e_s(92, 24, 5)); k(e_s(96, 7, 5)); k(32'h0000_0000);

        for (int unsigned o = 0; o <= 32'h30; o += 4) psq.push_back(A + o);
        psq.push_back(A + 32'h40); psq.push_back(A + 32'h38);
        for (int unsigned o = 32'h48; o <= 32'hD0; o += 4) psq.push_back(A + o);
        psq.push_back(A + 32'hD8); psq.push_back(A + 32'hDC); psq.push_back(A + 32'hE0);
        psq.push_back(A + 32'hE8); psq.push_back(A + 32'hEC); psq.push_back(A + 32'hF4);
        psq.push_back(A + 32'hF8);

        bw(32'h00, 32'hFFFF_FFFB); bw(32'h04, 32'hFFFF_FFFD); bw(32'h08, 32'h0000_000F);
        bw(32'h0C, 32'h1);         bw(32'h10, 32'hFFFF_FFFB); bw(32'h14, 32'h0);
        bw(32'h18, 32'h0);         bw(32'h1C, 32'hFFFF_FFFC); bw(32'h20, 32'h6);
        bw(32'h24, 32'h8000);      bw(32'h28, 32'h1);         bw(32'h2C, 32'hFFFF_FFF4);
        bw(32'h30, 32'hFFFF_FFFD); bw(32'h34, 32'h7FFF_FFFD); bw(32'h38, 32'hF);
        bw(32'h3C, 32'hB);         bw(32'h40, 32'h1);         bw(32'h44, 32'h1);
        bw(32'h48, 32'hFFFF_FFF0); bw(32'h4C, 32'h7F1);       bw(32'h50, 32'hF0);
        bw(32'h54, 32'h8000_0000); bw(32'h58, 32'h8000_10B0); bw(32'h5C, 32'h8000_00F0);
        bw(32'h60, 32'h0);

        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        dur_bekle("f1_hata");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2 kontrol("dur_istek", {31'b0, bellek_istek}, 32'd0);
        end
        kontrol("f1_ps_kalan", psq.size(), 0);
        kontrol("f1_yaz_kalan", yq.size(), 0);
        kontrol("sw_bekleme", ilk_say, 4);

        // Misaligned load halts without touching the bus
        sifirla();
        faz = 2; yasak = 0;
        temizle();
        k(e_u(32'h80001, 5, LUI)); k(e_i(2, 5, 2, 8, LOAD));
        psq.push_back(A);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        dur_bekle("f2_hata");
        repeat (2) @(posedge clk);
        kontrol("f2_yasak", yasak, 0);
        kontrol("f2_ps_kalan", psq.size(), 0);

        // Reset while a load waits on hazir
        sifirla();
        faz = 3;
        temizle();
        k(e_u(32'h80001, 5, LUI)); k(e_i(0, 5, 2, 9, LOAD));
        psq.push_back(A);
        tut_adres = D;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        begin
            int unsigned goruldu;
            goruldu = 0;
            for (int i = 0; i < 200 && goruldu == 0; i++) begin
                @(negedge clk);
                #2 if (bellek_istek && bellek_adres == D) goruldu = 1;
            end
            kontrol("f3_bellek", goruldu, 1);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 kontrol("f3_istek", {31'b0, bellek_istek}, 32'd0);
        kontrol("f3_yaz", {31'b0, bellek_yaz}, 32'd0);
        kontrol("f3_emekli", {31'b0, emekli}, 32'd0);
        kontrol("f3_adres", bellek_adres, A);
        repeat (3) @(posedge clk);
        kontrol("f3_ps_kalan", psq.size(), 0);
        kontrol("f3_hata", {31'b0, hata}, 32'd0);

        $display("Result: errors=%0d of %0d checks", hata_say, toplam);
        $finish;
    end
endmodule
